// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM input pin and the consumer of its measurements.
// The capture block uses the master side; the consumer (or a bench) uses the slave side.
interface pwm_capture_if #(
  parameter int CNT_W = 32
);
  logic             pwm_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic             timeout;
  logic             stuck_level;

  modport master (
    input  pwm_in,
    output high_cnt, period_cnt, meas_valid, timeout, stuck_level
  );

  modport slave (
    output pwm_in,
    input  high_cnt, period_cnt, meas_valid, timeout, stuck_level
  );
endinterface

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input, with loss-of-signal timeout.
// Optional glitch filter on the synchronized input when PWM_CAP_FILTER_EN is defined.
module pwm_capture #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CNT = 2_000_000
`ifdef PWM_CAP_FILTER_EN
  , parameter int FILT_LEN  = 4
`endif
) (
  input logic           clk,
  input logic           rst,
  pwm_capture_if.master bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT_CNT);

  logic [1:0] sync_q;
  logic       lvl;
  logic       lvl_q;
  logic       rise;
  logic       fall;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] p_ctr, p_nx, p_inc;
  logic [CNT_W-1:0] h_ctr, h_nx, h_inc;
  logic [CNT_W-1:0] h_lat, h_lat_nx;
  logic [CNT_W-1:0] high_q, high_nx;
  logic [CNT_W-1:0] period_q, period_nx;
  logic             valid_q, valid_nx;
  logic             timeout_q, timeout_nx;
  logic             stuck_q, stuck_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], bus.pwm_in};
  end

`ifdef PWM_CAP_FILTER_EN
  localparam int FC_W = $clog2(FILT_LEN + 1);

  logic [FC_W-1:0] filt_cnt;
  logic            filt_lvl;

  // The filtered level follows only after FILT_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_cnt <= '0;
      filt_lvl <= 1'b0;
    end else if (sync_q[1] == filt_lvl) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FC_W'(FILT_LEN - 1)) begin
      filt_lvl <= sync_q[1];
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FC_W'(1);
    end
  end

  assign lvl = filt_lvl;
`else
  assign lvl = sync_q[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lvl_q <= 1'b0;
    else     lvl_q <= lvl;
  end

  assign rise  = lvl & ~lvl_q;
  assign fall  = ~lvl & lvl_q;
  assign p_inc = (p_ctr == CNT_MAX) ? p_ctr : p_ctr + CNT_W'(1);
  assign h_inc = (h_ctr == CNT_MAX) ? h_ctr : h_ctr + CNT_W'(1);

  // A rise in LOW closes a period; a rise in the same cycle as the timeout limit wins.
  always_comb begin
    state_nx   = state;
    p_nx       = p_ctr;
    h_nx       = h_ctr;
    h_lat_nx   = h_lat;
    high_nx    = high_q;
    period_nx  = period_q;
    valid_nx   = 1'b0;
    timeout_nx = timeout_q;
    stuck_nx   = stuck_q;
    case (state)
      IDLE: begin
        p_nx = '0;
        h_nx = '0;
        if (rise) begin
          state_nx = HIGH;
          p_nx     = CNT_W'(1);
          h_nx     = CNT_W'(1);
        end
      end
      HIGH: begin
        p_nx = p_inc;
        h_nx = h_inc;
        if (p_ctr >= TMO_LIM) begin
          state_nx   = IDLE;
          timeout_nx = 1'b1;
          stuck_nx   = lvl;
          p_nx       = '0;
          h_nx       = '0;
        end else if (fall) begin
          state_nx = LOW;
          h_lat_nx = h_ctr;
        end
      end
      LOW: begin
        p_nx = p_inc;
        if (rise) begin
          state_nx   = HIGH;
          period_nx  = p_ctr;
          high_nx    = h_lat;
          valid_nx   = 1'b1;
          timeout_nx = 1'b0;
          p_nx       = CNT_W'(1);
          h_nx       = CNT_W'(1);
        end else if (p_ctr >= TMO_LIM) begin
          state_nx   = IDLE;
          timeout_nx = 1'b1;
          stuck_nx   = lvl;
          p_nx       = '0;
          h_nx       = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        p_nx     = '0;
        h_nx     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      p_ctr     <= '0;
      h_ctr     <= '0;
      h_lat     <= '0;
      high_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      state     <= state_nx;
      p_ctr     <= p_nx;
      h_ctr     <= h_nx;
      h_lat     <= h_lat_nx;
      high_q    <= high_nx;
      period_q  <= period_nx;
      valid_q   <= valid_nx;
      timeout_q <= timeout_nx;
      stuck_q   <= stuck_nx;
    end
  end

  assign bus.high_cnt    = high_q;
  assign bus.period_cnt  = period_q;
  assign bus.meas_valid  = valid_q;
  assign bus.timeout     = timeout_q;
  assign bus.stuck_level = stuck_q;

endmodule
